// File: rtl/bht_update_queue.sv
// BHT update queue: in-order FIFO decoupling resolved branches from BHT training.
// Optional macro BHT_UPDQ_STATS_EN builds a saturating drop counter.
package config_pkg;
   typedef struct packed {
      int unsigned VLEN;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32};
endpackage

module bht_update_queue #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         res_valid_i,
   input  logic [CVA6Cfg.VLEN-1:0]      res_pc_i,
   input  logic                         res_taken_i,
   output logic                         bht_upd_valid_o,
   output logic [CVA6Cfg.VLEN-1:0]      bht_upd_pc_o,
   output logic                         bht_upd_taken_o,
   input  logic                         bht_upd_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         drop_o,
   output logic [15:0]                  drop_cnt_o
);

   localparam int unsigned VLEN = CVA6Cfg.VLEN;
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bht_update_queue: DEPTH must be a power of 2 and >= 2");
   end

   typedef struct packed {
      logic [VLEN-1:0] pc;
      logic            taken;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            valid;
   logic            full;
   logic            enq;
   logic            deq;
   entry_t          head;

   assign valid = (count_q != '0);
   assign full  = (count_q == CW'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // A full queue still accepts when the head leaves in the same cycle.
   assign deq = valid & bht_upd_ready_i & ~flush_i;
   assign enq = res_valid_i & ~flush_i & (~full | deq);

   assign bht_upd_valid_o = valid;
   assign bht_upd_pc_o    = valid ? head.pc : '0;
   assign bht_upd_taken_o = valid ? head.taken : 1'b0;
   assign count_o         = count_q;
   assign full_o          = full;
   assign drop_o          = res_valid_i & ~flush_i & full & ~deq;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            mem_d[wr_ptr_q] = '{pc: res_pc_i, taken: res_taken_i};
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifdef BHT_UPDQ_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_o && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Testbench for bht_update_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_bht_update_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        rv;
   logic [31:0] pc;
   logic        tk;
   logic        rdy;
   logic        o_valid;
   logic [31:0] o_pc;
   logic        o_taken;
   logic [2:0]  o_count;
   logic        o_full;
   logic        o_drop;
   logic [15:0] o_dcnt;

   int total = 0;
   int bad   = 0;

   logic [31:0] mq_pc [$];
   logic        mq_tk [$];
   int          mdrops = 0;

   bht_update_queue #(.DEPTH(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .res_valid_i    (rv),
      .res_pc_i       (pc),
      .res_taken_i    (tk),
      .bht_upd_valid_o(o_valid),
      .bht_upd_pc_o   (o_pc),
      .bht_upd_taken_o(o_taken),
      .bht_upd_ready_i(rdy),
      .count_o        (o_count),
      .full_o         (o_full),
      .drop_o         (o_drop),
      .drop_cnt_o     (o_dcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_dcnt();
`ifdef BHT_UPDQ_STATS_EN
      return (mdrops > 65535) ? 16'hFFFF : 16'(mdrops);
`else
      return 16'h0;
`endif
   endfunction

   // Advance one clock edge and apply the queue rules to the model.
   task automatic tick();
      int  n;
      bit  d;
      @(posedge clk);
      n = mq_pc.size();
      if (rst) begin
         mq_pc.delete();
         mq_tk.delete();
         mdrops = 0;
      end else if (flush) begin
         mq_pc.delete();
         mq_tk.delete();
      end else begin
         d = (n != 0) && rdy;
         if (d) begin
            void'(mq_pc.pop_front());
            void'(mq_tk.pop_front());
         end
         if (rv && (n < 4 || d)) begin
            mq_pc.push_back(pc);
            mq_tk.push_back(tk);
         end else if (rv) begin
            mdrops++;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0;
      rv    = 1'b0;
      pc    = '0;
      tk    = 1'b0;
      rdy   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      total++;
      if (o_valid !== 1'b0 || o_count !== 3'd0 || o_dcnt !== 16'h0) begin
         bad++;
         $display("FAIL reset_hold valid=%b count=%0d dcnt=%0d want 0/0/0",
                  o_valid, o_count, o_dcnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (o_valid !== 1'b0 || o_count !== 3'd0 ||
             o_full !== 1'b0 || o_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle%0d valid=%b count=%0d full=%b pc=%h want 0",
                     i, o_valid, o_count, o_full, o_pc);
         end
      end
   endtask

   task automatic test_single();
      rdy = 1'b1;
      rv  = 1'b1;
      pc  = 32'h8000_1000;
      tk  = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_nobypass valid=%b want 0", o_valid);
      end
      tick();
      rv = 1'b0;
      #1;
      total++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8000_1000 || o_taken !== 1'b1) begin
         bad++;
         $display("FAIL single_out valid=%b pc=%h tk=%b want 1/80001000/1",
                  o_valid, o_pc, o_taken);
      end
      tick();
      total++;
      if (o_valid !== 1'b0 || o_count !== 3'd0) begin
         bad++;
         $display("FAIL single_drain valid=%b count=%0d want 0/0",
                  o_valid, o_count);
      end
   endtask

   task automatic test_fill_overflow();
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rv = 1'b1;
         pc = 32'h100 + 32'(4 * i);
         tk = i[0];
         #1;
         total++;
         if (o_drop !== (i == 4)) begin
            bad++;
            $display("FAIL fill_drop%0d drop=%b want %b", i, o_drop, i == 4);
         end
         if (i == 4) begin
            total++;
            if (o_full !== 1'b1 || o_count !== 3'd4) begin
               bad++;
               $display("FAIL fill_full full=%b count=%0d want 1/4",
                        o_full, o_count);
            end
         end
         tick();
      end
      rv = 1'b0;
      #1;
      total++;
      if (o_dcnt !== exp_dcnt()) begin
         bad++;
         $display("FAIL fill_dcnt dcnt=%0d want %0d", o_dcnt, exp_dcnt());
      end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (o_valid !== 1'b1 || o_pc !== 32'h100 + 32'(4 * i) ||
             o_taken !== i[0]) begin
            bad++;
            $display("FAIL fill_order%0d valid=%b pc=%h tk=%b want 1/%h/%b",
                     i, o_valid, o_pc, o_taken, 32'h100 + 32'(4 * i), i[0]);
         end
         tick();
      end
      total++;
      if (o_valid !== 1'b0) begin
         bad++;
         $display("FAIL fill_nodropped valid=%b pc=%h want empty", o_valid, o_pc);
      end
   endtask

   task automatic test_full_enq_deq();
      logic [31:0] want [4];
      want = '{32'h404, 32'h408, 32'h40C, 32'h200};
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rv = 1'b1;
         pc = 32'h400 + 32'(4 * i);
         tk = 1'b0;
         tick();
      end
      rdy = 1'b1;
      rv  = 1'b1;
      pc  = 32'h200;
      tk  = 1'b1;
      #1;
      total++;
      if (o_drop !== 1'b0 || o_full !== 1'b1) begin
         bad++;
         $display("FAIL fulldeq_drop drop=%b full=%b want 0/1", o_drop, o_full);
      end
      tick();
      rv = 1'b0;
      total++;
      if (o_count !== 3'd4) begin
         bad++;
         $display("FAIL fulldeq_count count=%0d want 4", o_count);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (o_valid !== 1'b1 || o_pc !== want[i]) begin
            bad++;
            $display("FAIL fulldeq_order%0d valid=%b pc=%h want 1/%h",
                     i, o_valid, o_pc, want[i]);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic [15:0] dc_before;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rv = 1'b1;
         pc = 32'h500 + 32'(4 * i);
         tick();
      end
      dc_before = o_dcnt;
      flush = 1'b1;
      rv    = 1'b1;
      rdy   = 1'b1;
      pc    = 32'h5F0;
      #1;
      total++;
      if (o_drop !== 1'b0 || o_count !== 3'd3) begin
         bad++;
         $display("FAIL flush_cycle drop=%b count=%0d want 0/3", o_drop, o_count);
      end
      tick();
      flush = 1'b0;
      rv    = 1'b0;
      total++;
      if (o_count !== 3'd0 || o_valid !== 1'b0 || o_dcnt !== dc_before) begin
         bad++;
         $display("FAIL flush_after count=%0d valid=%b dcnt=%0d want 0/0/%0d",
                  o_count, o_valid, o_dcnt, dc_before);
      end
   endtask

   task automatic test_async_reset();
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rv = 1'b1;
         pc = 32'h600 + 32'(4 * i);
         tick();
      end
      rv = 1'b0;
      total++;
      if (o_count !== 3'd2) begin
         bad++;
         $display("FAIL arst_pre count=%0d want 2", o_count);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0 || o_count !== 3'd0 || o_dcnt !== 16'h0) begin
         bad++;
         $display("FAIL arst_immediate valid=%b count=%0d dcnt=%0d want 0/0/0",
                  o_valid, o_count, o_dcnt);
      end
      tick();
      rst = 1'b0;
      rv  = 1'b1;
      rdy = 1'b1;
      pc  = 32'h300;
      tk  = 1'b1;
      tick();
      rv = 1'b0;
      total++;
      if (o_valid !== 1'b1 || o_pc !== 32'h300 || o_count !== 3'd1) begin
         bad++;
         $display("FAIL arst_first valid=%b pc=%h count=%0d want 1/300/1",
                  o_valid, o_pc, o_count);
      end
      tick();
   endtask

   task automatic test_random();
      bit          e_valid;
      logic [31:0] e_pc;
      bit          e_tk;
      bit          e_drop;
      int          n;
      for (int c = 0; c < 400; c++) begin
         rv    = ($urandom_range(0, 3) != 0);
         rdy   = ($urandom_range(0, 2) == 0);
         flush = ($urandom_range(0, 24) == 0);
         pc    = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h8000_0000;
         tk    = 1'($urandom);
         #1;
         n       = mq_pc.size();
         e_valid = (n != 0);
         e_pc    = e_valid ? mq_pc[0] : 32'h0;
         e_tk    = e_valid ? mq_tk[0] : 1'b0;
         e_drop  = rv && !flush && n == 4 && !(e_valid && rdy);
         total++;
         if (o_valid !== e_valid || o_pc !== e_pc || o_taken !== e_tk) begin
            bad++;
            $display("FAIL rand_head c=%0d got %b/%h/%b want %b/%h/%b",
                     c, o_valid, o_pc, o_taken, e_valid, e_pc, e_tk);
         end
         total++;
         if (o_count !== 3'(n) || o_full !== (n == 4) || o_drop !== e_drop) begin
            bad++;
            $display("FAIL rand_status c=%0d got cnt=%0d full=%b drop=%b want %0d/%b/%b",
                     c, o_count, o_full, o_drop, n, n == 4, e_drop);
         end
         total++;
         if (o_dcnt !== exp_dcnt()) begin
            bad++;
            $display("FAIL rand_dcnt c=%0d got %0d want %0d", c, o_dcnt, exp_dcnt());
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_enq_deq();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Buffers resolved-branch outcomes from the execute/branch unit and presents them, one per cycle, to the BHT update port.
- Sits directly upstream of the BHT training path, so that BHT update-port stalls never back-pressure execute.
- Built as an in-order circular FIFO with a ready/valid output handshake and a non-blocking input.
- Overflow drops the newest update and flags it.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core config. Only CVA6Cfg.VLEN is used, for PC width.
- DEPTH, 4: number of entries. Must be a power of 2 and at least 2; elaboration fails otherwise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous clear of all entries.
- res_valid_i  in  1  resolved-branch update present this cycle.
- res_pc_i  in  VLEN  virtual PC of the resolved branch.
- res_taken_i  in  1  resolved direction (1 = taken).
- bht_upd_valid_o  out  1  head entry valid toward the BHT.
- bht_upd_pc_o  out  VLEN  head entry PC.
- bht_upd_taken_o  out  1  head entry direction.
- bht_upd_ready_i  in  1  BHT accepts the head entry this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- full_o  out  1  occupancy == DEPTH.
- drop_o  out  1  one-cycle pulse: an input update was dropped this cycle.
- drop_cnt_o  out  16  saturating drop counter. Meaningful only with the optional feature enabled.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst_i asserted asynchronously forces wr_ptr = rd_ptr = 0 and count = 0.
  - Outputs under reset: bht_upd_valid_o = 0, bht_upd_pc_o = 0, bht_upd_taken_o = 0, count_o = 0, full_o = 0, drop_o = 0, drop_cnt_o = 0.
  - Entry storage need not be reset.
  - Reset mid-operation discards all entries. The first cycle after deassertion behaves as empty.
- Storage
  - DEPTH entries of {pc, taken}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH, with no special case at wrap.
  - count is kept as a separate register.
- Enqueue (enq)
  - enq = res_valid_i & ~flush_i & (count < DEPTH | deq).
  - Writes entry[wr_ptr] and increments wr_ptr.
- Dequeue (deq)
  - deq = bht_upd_valid_o & bht_upd_ready_i & ~flush_i.
  - Increments rd_ptr.
- Latency
  - No bypass. An entry enqueued at edge N appears on bht_upd_*_o after edge N, i.e. no earlier than the next cycle.
  - Outputs come directly from entry[rd_ptr] and the count register (registered, no input-to-output combinational path).
- Output validity
  - bht_upd_valid_o = (count != 0).
  - bht_upd_pc_o and bht_upd_taken_o are 0 when count == 0 (masked).
  - The head entry is held stable while valid & ~ready.
- count update
  - enq & ~deq: +1.
  - deq & ~enq: -1.
  - Both or neither: unchanged.
- Full plus simultaneous dequeue: the input is accepted (a slot frees the same cycle) and count stays at DEPTH.
- Overflow
  - drop_o = res_valid_i & ~flush_i & (count == DEPTH) & ~deq, combinational.
  - The incoming update is discarded. Existing entries are untouched.
- Flush
  - flush_i wins over every other event.
  - On the next edge: pointers and count go to 0.
  - A concurrent res_valid_i is discarded and does not count as a drop.
  - No deq occurs in the flush cycle.
- Ordering: strictly FIFO. No coalescing of equal PCs.

Optional Feature:
- Macro: BHT_UPDQ_STATS_EN.
- Defined:
  - drop_cnt_o is a 16-bit register that increments on each drop_o cycle and saturates at 16'hFFFF.
  - It is cleared only by rst_i; flush_i does not clear it.
- Undefined:
  - No counter logic is built.
  - drop_cnt_o is tied to 16'h0.
  - All other behaviour is identical.

Test Plan (DEPTH = 4):
- Reset then idle:
  - Hold rst_i for 3 cycles, release, no input.
  - Required: bht_upd_valid_o = 0, count_o = 0, full_o = 0, pc = 0 for 5 cycles.
- Single update latency:
  - res_valid_i = 1, pc = 0x80001000, taken = 1 at cycle N, bht_upd_ready_i = 1.
  - Required: bht_upd_valid_o = 1 with pc = 0x80001000, taken = 1 in cycle N+1 only; count_o back to 0 at N+2.
- Fill, overflow, order:
  - bht_upd_ready_i = 0; enqueue pcs 0x100, 0x104, 0x108, 0x10C, 0x110 on consecutive cycles.
  - Required: full_o = 1 after the 4th; drop_o = 1 on the 5th cycle; drop_cnt_o = 1 with the macro, 0 without.
  - Then ready = 1: outputs 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 0x110 never appears.
- Full with simultaneous enq/deq, and pointer wrap:
  - Queue full, ready = 1 and res_valid_i = 1 (pc = 0x200) in the same cycle.
  - Required: drop_o = 0; count_o stays 4; 0x200 is emitted 4th after draining; pointers wrap past DEPTH-1 with order preserved.
- Flush priority:
  - Queue holds 3 entries; assert flush_i with res_valid_i = 1 and ready = 1 in the same cycle.
  - Required: next cycle count_o = 0, bht_upd_valid_o = 0, drop_o = 0 in the flush cycle, no dequeue handshake counted.
- Async reset mid-stream:
  - Assert rst_i between clock edges while count = 2.
  - Required: bht_upd_valid_o and count_o drop to 0 immediately, without waiting for a clock edge; after release, an enqueue of pc = 0x300 is the first output.
